hazard_scoreboard: RTL and testbench
====================================

HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset, with ports as listed below.
REQ-002 clk  input  1  rising-edge clock, sole clock domain.
REQ-003 rst_n  input  1  synchronous active-low reset, sampled on rising clk.
REQ-004 IFIDRs, IFIDRt  input  5 each  source register numbers of the instruction in ID.
REQ-005 IDUsesRs, IDUsesRt  input  1 each  ID instruction actually reads Rs / Rt.
REQ-006 IDRegWrite, IDRd  input  1, 5  ID instruction writes the register IDRd.
REQ-007 IDLong  input  1  ID instruction is a multi-cycle op (mult/div) issued to the long unit.
REQ-008 IDExMemRead, IDExRt  input  1, 5  load in EX and its destination register.
REQ-009 LongDone, LongRd  input  1, 5  long unit writes back LongRd this cycle.
REQ-010 BranchTaken  input  1  taken branch resolved this cycle.
REQ-011 stall  output  1  hold PC and IF/ID.
REQ-012 bubble  output  1  zero ID/EX control signals.
REQ-013 flush  output  1  clear IF/ID.
REQ-014 pending  output  32  registered per-register pending-write bits.
REQ-015 busy  output  1  registered; a long op is in flight.
REQ-016 stallCount  output  16  registered count of stalled cycles.

Function
REQ-017 Register 0 SHALL never be pending, never cause a hazard, and never set pending[0].
REQ-018 Load-use hazard: IDExMemRead=1, IDExRt!=0, and IDExRt equals a used source (Rs with IDUsesRs, or Rt with IDUsesRt).
REQ-019 RAW hazard: a used nonzero source has its pending bit set.
REQ-020 WAW hazard: IDRegWrite=1, IDRd!=0, and pending[IDRd]=1.
REQ-021 Structural hazard: IDLong=1 and busy=1.
REQ-022 hz = OR of REQ-018 to REQ-021, combinational from the current inputs and registered state.
REQ-023 Hazards SHALL use only registered pending; a bit cleared at an edge releases the stall in the following cycle, with no same-cycle bypass.
REQ-024 flush = BranchTaken; stall = hz AND NOT BranchTaken; bubble = stall OR BranchTaken.
REQ-025 Issue occurs when IDLong=1, IDRegWrite=1, stall=0, and BranchTaken=0.
REQ-026 On issue, the next edge SHALL set pending[IDRd] (if IDRd!=0) and set busy.
REQ-027 LongDone=1 SHALL clear pending[LongRd] and busy at the next edge.
REQ-028 If issue and LongDone occur in the same cycle, busy SHALL end at 1, and the set of pending[IDRd] SHALL win over a clear of the same bit.
REQ-029 LongDone while busy=0 SHALL still clear pending[LongRd] and otherwise be ignored.
REQ-030 stallCount SHALL increment by 1 at each edge where stall=1, and saturate at 16'hFFFF.
REQ-031 Outputs stall, bubble, and flush SHALL have zero latency (combinational); pending, busy, and stallCount SHALL update at the clock edge.

Reset
REQ-032 When rst_n=0 at an edge, the next state SHALL be pending=0, busy=0, stallCount=0, regardless of simultaneous issue or LongDone.
REQ-033 During reset, stall and bubble SHALL follow REQ-024 from the reset-cleared state only after the edge; no issue is recorded.

Verification
REQ-034 Load-use: IDExMemRead=1, IDExRt=5, IFIDRs=5, IDUsesRs=1 -> stall=1, bubble=1, stallCount 0->1; next cycle with IDExMemRead=0 -> stall=0.
REQ-035 Long RAW: issue div with IDRd=8; next instruction reads $8 -> stall held until one cycle after LongDone with LongRd=8; pending[8] 1->0; busy 1->0.
REQ-036 Simultaneous events: busy=1, LongDone with LongRd=8, and new issue with IDRd=8 in the same cycle is impossible per REQ-021 (stall=1, no issue). With busy=0 and LongDone with LongRd=8 plus issue with IDRd=8 -> pending[8]=1, busy=1.
REQ-037 Branch priority: load-use hazard plus BranchTaken=1 -> flush=1, stall=0, bubble=1, no issue, stallCount unchanged.
REQ-038 $0 and saturation: IDExRt=0 with IFIDRs=0 -> stall=0. Force 65536 stall cycles -> stallCount=16'hFFFF and stays there.
REQ-039 Mid-operation reset: busy=1, pending[8]=1, rst_n=0 for one edge -> pending=0, busy=0, stallCount=0.

Source files
------------

// File: rtl/hazard_scoreboard.sv
// Pipeline hazard scoreboard: detects load-use, RAW, WAW and structural hazards,
// and tracks pending long-unit writes, long-unit occupancy and stalled cycles.
module hazard_scoreboard (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  IFIDRs,
    input  logic [4:0]  IFIDRt,
    input  logic        IDUsesRs,
    input  logic        IDUsesRt,
    input  logic        IDRegWrite,
    input  logic [4:0]  IDRd,
    input  logic        IDLong,
    input  logic        IDExMemRead,
    input  logic [4:0]  IDExRt,
    input  logic        LongDone,
    input  logic [4:0]  LongRd,
    input  logic        BranchTaken,
    output logic        stall,
    output logic        bubble,
    output logic        flush,
    output logic [31:0] pending,
    output logic        busy,
    output logic [15:0] stallCount
);

    logic        rsLive;
    logic        rtLive;
    logic        loadUse;
    logic        rawHazard;
    logic        wawHazard;
    logic        structHazard;
    logic        hz;
    logic        issue;
    logic [31:0] pendingNext;

    // Register 0 is hardwired, so it never participates in any hazard.
    assign rsLive = IDUsesRs && (IFIDRs != 5'd0);
    assign rtLive = IDUsesRt && (IFIDRt != 5'd0);

    assign loadUse = IDExMemRead && (IDExRt != 5'd0) &&
                     ((rsLive && (IFIDRs == IDExRt)) || (rtLive && (IFIDRt == IDExRt)));

    // Only the registered pending bits are consulted; no same-cycle bypass.
    assign rawHazard    = (rsLive && pending[IFIDRs]) || (rtLive && pending[IFIDRt]);
    assign wawHazard    = IDRegWrite && (IDRd != 5'd0) && pending[IDRd];
    assign structHazard = IDLong && busy;

    assign hz     = loadUse || rawHazard || wawHazard || structHazard;
    assign flush  = BranchTaken;
    assign stall  = hz && !BranchTaken;
    assign bubble = stall || BranchTaken;
    assign issue  = IDLong && IDRegWrite && !stall && !BranchTaken;

    // Clear first so a set of the same register by a new issue wins.
    always_comb begin
        pendingNext = pending;
        if (LongDone) begin
            pendingNext[LongRd] = 1'b0;
        end
        if (issue && (IDRd != 5'd0)) begin
            pendingNext[IDRd] = 1'b1;
        end
        pendingNext[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pending    <= '0;
            busy       <= 1'b0;
            stallCount <= '0;
        end else begin
            pending <= pendingNext;
            if (issue) begin
                busy <= 1'b1;
            end else if (LongDone) begin
                busy <= 1'b0;
            end
            if (stall && (stallCount != '1)) begin
                stallCount <= stallCount + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard: directed scenarios plus randomized
// traffic compared against a behavioural scoreboard model.
module tb_hazard_scoreboard;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [4:0]  IFIDRs, IFIDRt, IDRd, IDExRt, LongRd;
    logic        IDUsesRs, IDUsesRt, IDRegWrite, IDLong, IDExMemRead, LongDone, BranchTaken;
    logic        stall, bubble, flush, busy;
    logic [31:0] pending;
    logic [15:0] stallCount;

    int unsigned testsRun = 0;
    int unsigned testsFailed = 0;

    bit          modelPending [32];
    bit          modelBusy;
    int          modelCount;
    logic [15:0] savedCount;

    always #5 clk = ~clk;

    hazard_scoreboard dut (
        .clk(clk), .rst_n(rst_n),
        .IFIDRs(IFIDRs), .IFIDRt(IFIDRt), .IDUsesRs(IDUsesRs), .IDUsesRt(IDUsesRt),
        .IDRegWrite(IDRegWrite), .IDRd(IDRd), .IDLong(IDLong),
        .IDExMemRead(IDExMemRead), .IDExRt(IDExRt),
        .LongDone(LongDone), .LongRd(LongRd), .BranchTaken(BranchTaken),
        .stall(stall), .bubble(bubble), .flush(flush),
        .pending(pending), .busy(busy), .stallCount(stallCount)
    );

    task automatic checkVal(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        testsRun++;
        if (observed !== expected) begin
            testsFailed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic clearIn();
        IFIDRs = 0; IFIDRt = 0; IDUsesRs = 0; IDUsesRt = 0;
        IDRegWrite = 0; IDRd = 0; IDLong = 0;
        IDExMemRead = 0; IDExRt = 0;
        LongDone = 0; LongRd = 0; BranchTaken = 0;
    endtask

    function automatic bit srcHazard(input logic [4:0] r, input bit used);
        if (!used || r == 0) return 0;
        if (IDExMemRead && IDExRt == r) return 1;
        return modelPending[r];
    endfunction

    function automatic bit modelStall();
        bit h;
        h = srcHazard(IFIDRs, IDUsesRs) || srcHazard(IFIDRt, IDUsesRt);
        if (IDRegWrite && IDRd != 0 && modelPending[IDRd]) h = 1;
        if (IDLong && modelBusy) h = 1;
        return h && !BranchTaken;
    endfunction

    function automatic logic [31:0] modelPendingVec();
        logic [31:0] v = 0;
        for (int i = 0; i < 32; i++) v[i] = modelPending[i];
        return v;
    endfunction

    // Inputs are already driven (just after a falling edge); check, then clock once.
    task automatic cycle(input bit doCheck);
        bit expStall, didIssue;
        #1;
        expStall = modelStall();
        if (doCheck) begin
            checkVal("stall", stall, expStall);
            checkVal("bubble", bubble, expStall || BranchTaken);
            checkVal("flush", flush, BranchTaken);
            checkVal("pending", pending, modelPendingVec());
            checkVal("busy", busy, modelBusy);
            checkVal("stallCount", stallCount, modelCount);
        end
        @(posedge clk);
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) modelPending[i] = 0;
            modelBusy = 0;
            modelCount = 0;
        end else begin
            didIssue = IDLong && IDRegWrite && !expStall && !BranchTaken;
            if (LongDone) modelPending[LongRd] = 0;
            if (didIssue && IDRd != 0) modelPending[IDRd] = 1;
            if (didIssue) modelBusy = 1;
            else if (LongDone) modelBusy = 0;
            if (expStall && modelCount < 65535) modelCount++;
        end
        @(negedge clk);
    endtask

    task automatic issueDiv(input logic [4:0] rd);
        clearIn();
        IDLong = 1; IDRegWrite = 1; IDRd = rd;
        cycle(1);
    endtask

    initial begin
        clearIn();
        rst_n = 0;
        for (int i = 0; i < 32; i++) modelPending[i] = 0;
        modelBusy = 0;
        modelCount = 0;
        @(posedge clk);
        @(negedge clk);
        cycle(1);
        #1;
        checkVal("reset_pending", pending, 32'h0);
        checkVal("reset_busy", busy, 0);
        checkVal("reset_count", stallCount, 0);
        rst_n = 1;

        // Load-use
        clearIn();
        IDExMemRead = 1; IDExRt = 5; IFIDRs = 5; IDUsesRs = 1;
        #1;
        checkVal("lu_stall", stall, 1);
        checkVal("lu_bubble", bubble, 1);
        cycle(1);
        checkVal("lu_count", stallCount, 1);
        IDExMemRead = 0;
        #1;
        checkVal("lu_release", stall, 0);
        cycle(1);

        // Long RAW on $8
        issueDiv(8);
        checkVal("raw_pend_set", pending[8], 1);
        checkVal("raw_busy_set", busy, 1);
        clearIn();
        IFIDRs = 8; IDUsesRs = 1;
        for (int i = 0; i < 3; i++) cycle(1);
        LongDone = 1; LongRd = 8;
        #1;
        checkVal("raw_stall_done_cycle", stall, 1);
        cycle(1);
        LongDone = 0;
        checkVal("raw_pend_clr", pending[8], 0);
        checkVal("raw_busy_clr", busy, 0);
        checkVal("raw_release", stall, 0);
        cycle(1);

        // LongDone and issue of the same register with busy=0
        clearIn();
        LongDone = 1; LongRd = 8; IDLong = 1; IDRegWrite = 1; IDRd = 8;
        cycle(1);
        checkVal("simul_pend", pending[8], 1);
        checkVal("simul_busy", busy, 1);
        #1;
        checkVal("simul_busy_stall", stall, 1);
        cycle(1);
        checkVal("simul_busy_noissue", busy, 0);

        // Branch priority over load-use
        clearIn();
        IDExMemRead = 1; IDExRt = 5; IFIDRs = 5; IDUsesRs = 1; BranchTaken = 1;
        IDLong = 1; IDRegWrite = 1; IDRd = 9;
        savedCount = stallCount;
        #1;
        checkVal("br_flush", flush, 1);
        checkVal("br_stall", stall, 0);
        checkVal("br_bubble", bubble, 1);
        cycle(1);
        checkVal("br_count", stallCount, savedCount);
        checkVal("br_noissue", busy, 0);

        // Register 0
        clearIn();
        IDExMemRead = 1; IDExRt = 0; IFIDRs = 0; IDUsesRs = 1;
        #1;
        checkVal("zero_stall", stall, 0);
        cycle(1);
        issueDiv(0);
        checkVal("zero_pend", pending[0], 0);
        clearIn();
        LongDone = 1;
        cycle(1);

        // Mid-operation reset
        issueDiv(8);
        clearIn();
        rst_n = 0; LongDone = 1; LongRd = 3; IDLong = 1; IDRegWrite = 1; IDRd = 4;
        cycle(1);
        rst_n = 1;
        clearIn();
        checkVal("mrst_pending", pending, 0);
        checkVal("mrst_busy", busy, 0);
        checkVal("mrst_count", stallCount, 0);
        cycle(1);

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            IFIDRs      = 5'($urandom_range(0, 7));
            IFIDRt      = 5'($urandom_range(0, 7));
            IDUsesRs    = 1'($urandom);
            IDUsesRt    = 1'($urandom);
            IDLong      = ($urandom_range(0, 3) == 0);
            IDRegWrite  = IDLong || ($urandom_range(0, 1) == 0);
            IDRd        = 5'($urandom_range(0, 7));
            IDExMemRead = ($urandom_range(0, 3) == 0);
            IDExRt      = 5'($urandom_range(0, 7));
            LongDone    = ($urandom_range(0, 4) == 0);
            LongRd      = 5'($urandom_range(0, 7));
            BranchTaken = ($urandom_range(0, 9) == 0);
            rst_n       = ($urandom_range(0, 199) != 0);
            cycle(1);
        end
        rst_n = 1;

        // Saturation
        clearIn();
        cycle(1);
        IDExMemRead = 1; IDExRt = 5; IFIDRs = 5; IDUsesRs = 1;
        for (int n = 0; n < 65540; n++) cycle(n >= 65530);
        checkVal("sat_count", stallCount, 16'hFFFF);
        cycle(1);
        checkVal("sat_hold", stallCount, 16'hFFFF);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
